// File: rtl/beamformer_pkg.sv
// Shared definitions for the beamformer front end: streamer FSM states,
// sample-memory read latency and the "no valid index" marker.
package beamformer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } stream_state_e;

    localparam int MEM_LATENCY = 2;

    localparam logic [15:0] IDLE_INDEX = 16'hFFFF;

endpackage

// File: rtl/sample_streamer.sv
// Streams one frame of samples from an external synchronous RAM to the delay
// beamformer, holding each sample/index pair for HOLD_CYCLES cycles.
module sample_streamer
    import beamformer_pkg::*;
#(
    parameter int NUM_SAMPLES = 1024,
    parameter int HOLD_CYCLES = 4,
    parameter int MEM_LAT     = MEM_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [15:0] mem_addr,
    output logic        mem_rden,
    input  logic [31:0] mem_q,
    output logic [31:0] sample_value,
    output logic [15:0] sample_index,
    output logic        start_beamformer,
    input  logic        data_good,
    output logic [15:0] good_count,
    output logic        busy,
    output logic        done
);

    localparam int SW = $clog2(HOLD_CYCLES);

    stream_state_e stateQ, stateD;
    logic [SW-1:0] slotQ, slotD;
    logic [15:0]   addrQ, addrD;
    logic          drainQ, drainD;
    logic [31:0]   valueQ, valueD;
    logic [15:0]   indexQ, indexD;
    logic          beamQ, beamD;
    logic [15:0]   goodQ, goodD;

    logic slotLoad;
    logic slotLast;
    logic addrLast;

    assign slotLoad = (slotQ == SW'(MEM_LAT));
    assign slotLast = (slotQ == SW'(HOLD_CYCLES - 1));
    assign addrLast = (addrQ == 16'(NUM_SAMPLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= ST_IDLE;
            slotQ  <= '0;
            addrQ  <= '0;
            drainQ <= 1'b0;
            valueQ <= '0;
            indexQ <= IDLE_INDEX;
            beamQ  <= 1'b0;
            goodQ  <= '0;
        end else begin
            stateQ <= stateD;
            slotQ  <= slotD;
            addrQ  <= addrD;
            drainQ <= drainD;
            valueQ <= valueD;
            indexQ <= indexD;
            beamQ  <= beamD;
            goodQ  <= goodD;
        end
    end

    // After the last address, the drain window runs the slot counter once more
    // without reading, so the final index is held a full HOLD_CYCLES before DONE.
    always_comb begin
        stateD = stateQ;
        slotD  = slotQ;
        addrD  = addrQ;
        drainD = drainQ;
        valueD = valueQ;
        indexD = indexQ;
        beamD  = beamQ;
        goodD  = goodQ;

        if (beamQ && data_good && (goodQ != 16'hFFFF)) begin
            goodD = goodQ + 16'd1;
        end

        case (stateQ)
            ST_IDLE: begin
                if (start) begin
                    stateD = ST_FETCH;
                    slotD  = '0;
                    addrD  = '0;
                    drainD = 1'b0;
                    goodD  = '0;
                end
            end
            ST_FETCH: begin
                if (!drainQ && slotLoad) begin
                    valueD = mem_q;
                    indexD = addrQ;
                    beamD  = 1'b1;
                end
                if (drainQ && slotLoad) begin
                    stateD = ST_DONE;
                    beamD  = 1'b0;
                    slotD  = '0;
                end else if (slotLast) begin
                    slotD = '0;
                    if (addrLast) begin
                        drainD = 1'b1;
                    end else begin
                        addrD = addrQ + 16'd1;
                    end
                end else begin
                    slotD = slotQ + SW'(1);
                end
            end
            ST_DONE: begin
                stateD = ST_IDLE;
                slotD  = '0;
                addrD  = '0;
                drainD = 1'b0;
            end
            default: begin
                stateD = ST_IDLE;
            end
        endcase

        if (abort) begin
            stateD = ST_IDLE;
            slotD  = '0;
            addrD  = '0;
            drainD = 1'b0;
            indexD = IDLE_INDEX;
            beamD  = 1'b0;
            goodD  = goodQ;
        end
    end

    assign mem_addr         = addrQ;
    assign mem_rden         = (stateQ == ST_FETCH) && (slotQ == '0) && !drainQ;
    assign sample_value     = valueQ;
    assign sample_index     = indexQ;
    assign start_beamformer = beamQ;
    assign good_count       = goodQ;
    assign busy             = (stateQ != ST_IDLE);
    assign done             = (stateQ == ST_DONE);

endmodule
